line_engine: RTL

Parametrised Bresenham line rasteriser for the VGA frame-buffer path. Accepts an arbitrary start and end point per command, walks all eight octants, and emits one pixel coordinate per accepted handshake to the frame-buffer writer. Output uses a valid/ready stream so the writer can stall it. Command-level start/busy/done signals let the drawing controller queue lines back to back.

---
 rtl/line_engine.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/line_engine.sv
// line_engine: Bresenham line rasteriser feeding the frame-buffer writer.
// Walks all eight octants from (x0,y0) to (x1,y1) inclusive and emits one
// pixel per px_valid/px_ready handshake.
// Optional feature: define LINE_ENGINE_CLIP_EN to step silently over points
// outside SCREEN_W x SCREEN_H.
//
// Handshake: a pixel transfers at a rising edge where px_valid && px_ready.
// Once px_valid is high it stays high, with px_x/px_y stable, until that
// transfer happens. px_valid is registered, so it never depends
// combinationally on px_ready.
module line_engine #(
    parameter int COORD_W  = 9,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    state_t state;

    // Latched command endpoints
    logic [COORD_W-1:0] xs, ys, xe, ye;

    // Bresenham terms: dx >= 0, dy <= 0
    logic signed [COORD_W:0]   dx, dy;
    logic signed [COORD_W+1:0] err;
    logic                      sx_neg, sy_neg;

    // Combinational step and setup terms
    logic signed [COORD_W:0]   dx_setup, dy_setup;
    logic signed [COORD_W+1:0] err_setup;
    logic signed [COORD_W+2:0] e2, dx_w3, dy_w3;
    logic signed [COORD_W+1:0] dx_w2, dy_w2, err_next;
    logic                      step_x, step_y;
    logic [COORD_W-1:0]        nx, ny;
    logic                      at_end, advance;
    logic                      first_vis, next_vis;

    assign dbg_state = state;

    // Setup arithmetic from the latched endpoints
    always_comb begin
        dx_setup = (xe >= xs) ? ({1'b0, xe} - {1'b0, xs}) : ({1'b0, xs} - {1'b0, xe});
        dy_setup = (ye >= ys) ? ({1'b0, ys} - {1'b0, ye}) : ({1'b0, ye} - {1'b0, ys});
        err_setup = {dx_setup[COORD_W], dx_setup} + {dy_setup[COORD_W], dy_setup};
    end

    // Next point of the walk and the error term that goes with it
    always_comb begin
        dx_w2    = {dx[COORD_W], dx};
        dy_w2    = {dy[COORD_W], dy};
        dx_w3    = {{2{dx[COORD_W]}}, dx};
        dy_w3    = {{2{dy[COORD_W]}}, dy};
        e2       = {err, 1'b0};
        step_x   = (e2 >= dy_w3);
        step_y   = (e2 <= dx_w3);
        err_next = err + (step_x ? dy_w2 : '0) + (step_y ? dx_w2 : '0);
        nx       = px_x;
        ny       = px_y;
        if (step_x) nx = sx_neg ? (px_x - ONE) : (px_x + ONE);
        if (step_y) ny = sy_neg ? (px_y - ONE) : (px_y + ONE);
        at_end   = (px_x == xe) && (px_y == ye);
        // A clipped point (px_valid low in DRAW) moves on without a handshake
        advance  = px_valid ? px_ready : 1'b1;
    end

`ifdef LINE_ENGINE_CLIP_EN
    // Visibility of the first point and of the point being stepped to
    always_comb begin
        first_vis = (32'(xs) < SCREEN_W) && (32'(ys) < SCREEN_H);
        next_vis  = (32'(nx) < SCREEN_W) && (32'(ny) < SCREEN_H);
    end
`else
    // Every point is visible; the screen size plays no part
    always_comb begin
        first_vis = 1'b1;
        next_vis  = 1'b1;
    end

    logic unused_screen;
    assign unused_screen = (SCREEN_W > 0) ^ (SCREEN_H > 0);
`endif

    // Command FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            px_valid <= 1'b0;
            px_x     <= '0;
            px_y     <= '0;
            xs       <= '0;
            ys       <= '0;
            xe       <= '0;
            ye       <= '0;
            dx       <= '0;
            dy       <= '0;
            err      <= '0;
            sx_neg   <= 1'b0;
            sy_neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    px_valid <= 1'b0;
                    if (start) begin
                        xs    <= x0;
                        ys    <= y0;
                        xe    <= x1;
                        ye    <= y1;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    dx       <= dx_setup;
                    dy       <= dy_setup;
                    err      <= err_setup;
                    sx_neg   <= !(xs < xe);
                    sy_neg   <= !(ys < ye);
                    px_x     <= xs;
                    px_y     <= ys;
                    px_valid <= first_vis;
                    state    <= DRAW;
                end
                DRAW: begin
                    if (advance) begin
                        if (at_end) begin
                            px_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            px_x     <= nx;
                            px_y     <= ny;
                            err      <= err_next;
                            px_valid <= next_vis;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
